// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the audio pipeline power/enable sequencer.
// Benches and the controller use the same state encoding and default timings.
package pwr_seq_pkg;

    localparam logic [2:0] S_OFF      = 3'd0;
    localparam logic [2:0] S_SETTLE   = 3'd1;
    localparam logic [2:0] S_FILL     = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_COOLDOWN = 3'd5;

    typedef enum logic [2:0] {
        ST_OFF      = S_OFF,
        ST_SETTLE   = S_SETTLE,
        ST_FILL     = S_FILL,
        ST_RUN      = S_RUN,
        ST_DRAIN    = S_DRAIN,
        ST_COOLDOWN = S_COOLDOWN
    } state_e;

    localparam int unsigned DEF_SETTLE_CYCLES   = 5;
    localparam int unsigned DEF_FILL_CYCLES     = 4;
    localparam int unsigned DEF_DRAIN_MAX       = 8;
    localparam int unsigned DEF_COOLDOWN_CYCLES = 3;

    typedef struct packed {
        logic pdm_clk_en;
        logic fe_en;
        logic nn_en;
        logic ready;
        logic busy;
    } seq_out_t;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pwr_seq.sv
// Power/enable sequencer: ordered bring-up of PDM clock, front-end and NN,
// drain of in-flight inference on disable, and a cooldown lockout.
module pwr_seq
    import pwr_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned FILL_CYCLES     = DEF_FILL_CYCLES,
    parameter int unsigned DRAIN_MAX       = DEF_DRAIN_MAX,
    parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic nn_busy_i,
    output logic pdm_clk_en_o,
    output logic fe_en_o,
    output logic nn_en_o,
    output logic ready_o,
    output logic busy_o
);

    localparam int unsigned CNT_BW =
        $clog2(max4(SETTLE_CYCLES, FILL_CYCLES, DRAIN_MAX, COOLDOWN_CYCLES) + 1);

    localparam logic [CNT_BW-1:0] SETTLE_LAST   = CNT_BW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_BW-1:0] FILL_LAST     = CNT_BW'(FILL_CYCLES - 1);
    localparam logic [CNT_BW-1:0] DRAIN_LAST    = CNT_BW'(DRAIN_MAX - 1);
    localparam logic [CNT_BW-1:0] COOLDOWN_LAST = CNT_BW'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_BW-1:0] CNT_SAT       = {CNT_BW{1'b1}};

    state_e            state_q, state_d;
    logic [CNT_BW-1:0] cnt_q;
    seq_out_t          outs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Untimed states (OFF, RUN) can dwell indefinitely, so saturate
            // instead of wrapping.
            if (state_d != state_q)
                cnt_q <= '0;
            else if (cnt_q != CNT_SAT)
                cnt_q <= cnt_q + CNT_BW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:
                if (en_i) state_d = ST_SETTLE;
            ST_SETTLE:
                // A dropped enable wins over a timer expiry in the same cycle.
                if (!en_i)                    state_d = ST_COOLDOWN;
                else if (cnt_q == SETTLE_LAST) state_d = ST_FILL;
            ST_FILL:
                if (!en_i)                  state_d = ST_COOLDOWN;
                else if (cnt_q == FILL_LAST) state_d = ST_RUN;
            ST_RUN:
                if (!en_i) state_d = ST_DRAIN;
            ST_DRAIN:
                // en_i is deliberately not looked at: a drain always finishes.
                if (!nn_busy_i || cnt_q == DRAIN_LAST) state_d = ST_COOLDOWN;
            ST_COOLDOWN:
                if (cnt_q == COOLDOWN_LAST) state_d = ST_OFF;
            default:
                state_d = ST_OFF;
        endcase
    end

    always_comb begin
        outs = '0;
        case (state_q)
            ST_SETTLE: begin
                outs.pdm_clk_en = 1'b1;
                outs.busy       = 1'b1;
            end
            ST_FILL: begin
                outs.pdm_clk_en = 1'b1;
                outs.fe_en      = 1'b1;
                outs.busy       = 1'b1;
            end
            ST_RUN: begin
                outs.pdm_clk_en = 1'b1;
                outs.fe_en      = 1'b1;
                outs.nn_en      = 1'b1;
                outs.ready      = 1'b1;
                outs.busy       = 1'b1;
            end
            ST_DRAIN: begin
                outs.pdm_clk_en = 1'b1;
                outs.fe_en      = 1'b1;
                outs.nn_en      = 1'b1;
                outs.busy       = 1'b1;
            end
            ST_COOLDOWN:
                outs.busy = 1'b1;
            default:
                outs = '0;
        endcase
    end

    assign pdm_clk_en_o = outs.pdm_clk_en;
    assign fe_en_o      = outs.fe_en;
    assign nn_en_o      = outs.nn_en;
    assign ready_o      = outs.ready;
    assign busy_o       = outs.busy;

endmodule

// File: doc/pwr_seq.md
Name: pwr_seq

Overview:
- Power/enable sequencer between the top-level pipeline controller and the audio pipeline.
- Turns one level-sensitive enable into an ordered bring-up: PDM mic clock, then front-end (filter/MFCC), then neural-net inference.
- On disable, lets an in-flight inference drain, then gates everything off and enforces a cooldown before another bring-up is accepted.

Parameters:
- SETTLE_CYCLES, 5: cycles the PDM clock runs before the front-end is enabled (mic startup); must be >= 1.
- FILL_CYCLES, 4: cycles the front-end runs before the NN is enabled (window fill); must be >= 1.
- DRAIN_MAX, 8: maximum cycles to wait for nn_busy_i to fall after disable; must be >= 1.
- COOLDOWN_CYCLES, 3: cycles all outputs stay off after shutdown, with en_i ignored; must be >= 1.
- CNT_BW, derived localparam: $clog2(max of the four cycle parameters + 1).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- en_i  in  1  pipeline enable request from the controller; level-sensitive
- nn_busy_i  in  1  NN inference in progress
- pdm_clk_en_o  out  1  PDM microphone clock enable
- fe_en_o  out  1  front-end enable
- nn_en_o  out  1  NN enable
- ready_o  out  1  pipeline fully up (RUN state)
- busy_o  out  1  high in any state other than OFF

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high, port rst_i.
  - Asserting rst_i forces state=OFF, counter=0 and all outputs 0 immediately, including mid-sequence.
- Outputs: pure decode of the registered state; no combinational path from any input to any output.
- Counter:
  - Single CNT_BW-bit counter.
  - Cleared on every state transition; incremented each cycle the state is held.
  - Never wraps: every timed state exits at count N-1.
- State machine (transitions at clk_i rising edge):
  - OFF: all outputs 0. en_i=1 -> SETTLE.
  - SETTLE: pdm_clk_en_o=1. en_i=0 -> COOLDOWN; else counter==SETTLE_CYCLES-1 -> FILL. Dwell is exactly SETTLE_CYCLES.
  - FILL: pdm_clk_en_o=1, fe_en_o=1. en_i=0 -> COOLDOWN; else counter==FILL_CYCLES-1 -> RUN.
  - RUN: pdm/fe/nn enables=1, ready_o=1. en_i=0 -> DRAIN.
  - DRAIN: pdm/fe/nn enables=1, ready_o=0. nn_busy_i=0 -> COOLDOWN; else counter==DRAIN_MAX-1 -> COOLDOWN (timeout). The timeout does not wait for nn_busy_i.
  - COOLDOWN: all enables 0, busy_o=1. counter==COOLDOWN_CYCLES-1 -> OFF. en_i is ignored throughout.
  - Illegal encoding -> OFF.
- busy_o=1 in SETTLE, FILL, RUN, DRAIN and COOLDOWN.
- Priority and edge cases:
  - en_i falling takes priority over a simultaneous timer expiry in SETTLE/FILL.
  - en_i rising again during DRAIN is ignored; DRAIN completes to COOLDOWN.
  - After COOLDOWN, OFF is entered for at least one cycle before SETTLE.
- Latency from en_i sampled 1 at edge E0 (from OFF):
  - pdm_clk_en_o high after E0.
  - fe_en_o high after E0+SETTLE_CYCLES.
  - nn_en_o and ready_o high after E0+SETTLE_CYCLES+FILL_CYCLES.

Decomposition:
- Shared package pwr_seq_pkg holds:
  - state encoding localparams (OFF=0, SETTLE=1, FILL=2, RUN=3, DRAIN=4, COOLDOWN=5; 3-bit);
  - default cycle counts, so the controller and benches share them.
- Sub-module: none required. The counter is simple enough to live inline.

Test Plan:
- Bring-up: reset, en_i=1 before E0 -> pdm_clk_en_o=1 from E0, fe_en_o=1 from E5, nn_en_o=ready_o=1 from E9; busy_o=1 from E0.
- Abort during SETTLE: en_i=1 at E0, en_i=0 at E2 -> outputs 0 after E2 (COOLDOWN); busy_o falls after E5; fe_en_o never asserts.
- Normal drain: in RUN, drop en_i at E0 with nn_busy_i=1 until E3 -> nn_en_o held through E3; all enables 0 after E4; busy_o=0 after E7.
- Drain timeout: in RUN, drop en_i with nn_busy_i stuck 1 -> enables drop exactly 8 cycles later; then 3 cycles of COOLDOWN, then OFF.
- Cooldown lockout: en_i re-asserted and held throughout COOLDOWN -> no enable during COOLDOWN; one cycle OFF; pdm_clk_en_o re-asserts on the following edge.
- Async reset: assert rst_i mid-RUN between clock edges -> all outputs 0 before the next edge; after release with en_i=1, a full bring-up is repeated from SETTLE.
